// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: hold, shifts, rotates, arithmetic shift, load and clear,
// with a saturating shift counter and a one-shot full-word pulse.
module universal_shift_register #(
    parameter int unsigned WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    typedef enum logic [2:0] {
        ModeHold  = 3'b000,
        ModeShl   = 3'b001,
        ModeShr   = 3'b010,
        ModeRol   = 3'b011,
        ModeRor   = 3'b100,
        ModeAsr   = 3'b101,
        ModeLoad  = 3'b110,
        ModeClear = 3'b111
    } mode_e;

    localparam logic [CW-1:0] CntFull = CW'(WIDTH);
    localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

    mode_e            op;
    logic [WIDTH-1:0] q_d;
    logic [CW-1:0]    cnt_d;
    logic             done_d;
    logic             is_shift;
    logic             is_reload;

    assign op        = mode_e'(mode);
    assign is_shift  = (op != ModeHold) && (op != ModeLoad) && (op != ModeClear);
    assign is_reload = (op == ModeLoad) || (op == ModeClear);

    always_comb begin
        q_d    = q;
        cnt_d  = cnt;
        done_d = 1'b0;
        if (en) begin
            unique case (op)
                ModeHold:  q_d = q;
                ModeShl:   q_d = {q[WIDTH-2:0], sin_l};
                ModeShr:   q_d = {sin_r, q[WIDTH-1:1]};
                ModeRol:   q_d = {q[WIDTH-2:0], q[WIDTH-1]};
                ModeRor:   q_d = {q[0], q[WIDTH-1:1]};
                ModeAsr:   q_d = {q[WIDTH-1], q[WIDTH-1:1]};
                ModeLoad:  q_d = d;
                ModeClear: q_d = '0;
            endcase

            // Reload wins over saturation; done fires only on the WIDTH-1 -> WIDTH step.
            if (is_reload) begin
                cnt_d = '0;
            end else if (is_shift) begin
                if (cnt != CntFull) begin
                    cnt_d = cnt + CW'(1);
                end
                done_d = (cnt == CntLast);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= RESET_VAL;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            q    <= q_d;
            cnt  <= cnt_d;
            done <= done_d;
        end
    end

    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=4): directed scenarios plus
// randomized operations checked against an arithmetic reference model.
module tb_universal_shift_register;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic       sin_l;
    logic       sin_r;
    logic [3:0] d;
    logic [3:0] q;
    logic       sout_l;
    logic       sout_r;
    logic [2:0] cnt;
    logic       done;

    int total = 0;
    int bad   = 0;

    // Reference model state: register value as an integer 0..15.
    int m_q    = 0;
    int m_cnt  = 0;
    bit m_done = 0;

    universal_shift_register #(
        .WIDTH    (4),
        .RESET_VAL(4'b0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .sin_l (sin_l),
        .sin_r (sin_r),
        .d     (d),
        .q     (q),
        .sout_l(sout_l),
        .sout_r(sout_r),
        .cnt   (cnt),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_q    = 0;
        m_cnt  = 0;
        m_done = 0;
    endtask

    // Drive one operation, clock it, advance the model; leaves time at posedge+1.
    task automatic op(input bit e, input int md, input bit sl, input bit sr, input int dv);
        int prev;
        en    = e;
        mode  = md[2:0];
        sin_l = sl;
        sin_r = sr;
        d     = dv[3:0];
        @(posedge clk);
        #1;
        m_done = 0;
        if (e) begin
            prev = m_cnt;
            case (md)
                1: m_q = (m_q * 2 + int'(sl)) % 16;
                2: m_q = m_q / 2 + int'(sr) * 8;
                3: m_q = (m_q * 2) % 16 + m_q / 8;
                4: m_q = m_q / 2 + (m_q % 2) * 8;
                5: m_q = m_q / 2 + ((m_q >= 8) ? 8 : 0);
                6: begin m_q = dv % 16; m_cnt = 0; end
                7: begin m_q = 0; m_cnt = 0; end
                default: ;
            endcase
            if (md >= 1 && md <= 5) begin
                if (m_cnt < 4) m_cnt++;
                m_done = (prev == 3) && (m_cnt == 4);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        en = 1'b0; mode = 3'd0; sin_l = 1'b0; sin_r = 1'b0; d = 4'd0;
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        total++;
        if (q !== 4'b0000) begin bad++; $display("FAIL reset_q: got %b want 0000", q); end
        total++;
        if (cnt !== 3'd0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_cnt_done: got cnt=%0d done=%b want 0/0", cnt, done);
        end
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        op(1, 6, 0, 0, 4'b1011);
        total++;
        if (q !== 4'b1011 || cnt !== 3'd0) begin
            bad++; $display("FAIL load_1011: got q=%b cnt=%0d want 1011/0", q, cnt);
        end
        total++;
        if (sout_l !== 1'b1 || sout_r !== 1'b1) begin
            bad++; $display("FAIL load_sout: got %b%b want 11", sout_l, sout_r);
        end
    endtask

    task automatic test_deserialize();
        bit sins [4] = '{1, 0, 1, 1};
        int exp_q [4] = '{1, 2, 5, 11};
        op(1, 7, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            op(1, 1, sins[i], 0, 0);
            total++;
            if (q !== exp_q[i][3:0] || cnt !== 3'(i + 1) || done !== (i == 3)) begin
                bad++;
                $display("FAIL shl_step%0d: got q=%b cnt=%0d done=%b want %b/%0d/%b",
                         i, q, cnt, done, exp_q[i][3:0], i + 1, i == 3);
            end
        end
        op(1, 1, 0, 0, 0);
        total++;
        if (q !== 4'b0110 || cnt !== 3'd4 || done !== 1'b0) begin
            bad++; $display("FAIL shl_saturate: got q=%b cnt=%0d done=%b want 0110/4/0",
                            q, cnt, done);
        end
    endtask

    task automatic test_rotate_asr();
        int modes [6] = '{3, 4, 4, 5, 5, 5};
        int exp_q [6] = '{4'b0011, 4'b1001, 4'b1100, 4'b1100, 4'b1110, 4'b1111};
        op(1, 6, 0, 0, 4'b1001);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) op(1, 6, 0, 0, 4'b1000);
            op(1, modes[i], 0, 0, 0);
            total++;
            if (q !== exp_q[i][3:0]) begin
                bad++; $display("FAIL rot_asr_step%0d: got %b want %b", i, q, exp_q[i][3:0]);
            end
        end
    endtask

    task automatic test_shr();
        op(1, 6, 0, 0, 4'b0110);
        op(1, 2, 0, 1, 0);
        total++;
        if (q !== 4'b1011 || sout_r !== 1'b1 || sout_l !== 1'b1) begin
            bad++; $display("FAIL shr_sin1: got q=%b sout_r=%b want 1011/1", q, sout_r);
        end
        op(1, 2, 0, 0, 0);
        total++;
        if (q !== 4'b0101 || sout_r !== 1'b1 || sout_l !== 1'b0) begin
            bad++; $display("FAIL shr_sin0: got q=%b sout_r=%b want 0101/1", q, sout_r);
        end
    endtask

    task automatic test_enable();
        op(1, 6, 0, 0, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            op(0, 1, 1, 0, 0);
            total++;
            if (q !== 4'b1010 || cnt !== 3'd0 || done !== 1'b0) begin
                bad++; $display("FAIL en_low%0d: got q=%b cnt=%0d done=%b want 1010/0/0",
                                i, q, cnt, done);
            end
        end
        op(1, 1, 0, 0, 0);
        total++;
        if (q !== 4'b0100 || cnt !== 3'd1) begin
            bad++; $display("FAIL en_resume: got q=%b cnt=%0d want 0100/1", q, cnt);
        end
    endtask

    task automatic test_reset_midword();
        int pulses = 0;
        op(1, 7, 0, 0, 0);
        repeat (3) op(1, 1, 1, 0, 0);
        total++;
        if (cnt !== 3'd3) begin bad++; $display("FAIL midword_cnt: got %0d want 3", cnt); end
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (q !== 4'b0000 || cnt !== 3'd0 || done !== 1'b0) begin
            bad++; $display("FAIL midword_reset: got q=%b cnt=%0d done=%b want 0000/0/0",
                            q, cnt, done);
        end
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            op(1, 1, 1, 0, 0);
            if (done === 1'b1) pulses++;
            total++;
            if (done !== (i == 3) || cnt !== 3'(i + 1)) begin
                bad++; $display("FAIL midword_shift%0d: got cnt=%0d done=%b want %0d/%b",
                                i, cnt, done, i + 1, i == 3);
            end
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL midword_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_random();
        op(1, 7, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            op($urandom_range(0, 7) != 0, int'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
            total++;
            if (q !== m_q[3:0] || sout_l !== m_q[3] || sout_r !== m_q[0]) begin
                bad++; $display("FAIL rand_q%0d: got q=%b sout=%b%b want %b",
                                i, q, sout_l, sout_r, m_q[3:0]);
            end
            total++;
            if (cnt !== m_cnt[2:0] || done !== m_done) begin
                bad++; $display("FAIL rand_cnt%0d: got cnt=%0d done=%b want %0d/%b",
                                i, cnt, done, m_cnt, m_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_deserialize();
        test_rotate_asr();
        test_shr();
        test_enable();
        test_reset_midword();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
